aes_sbox_pipe: RTL and testbench
================================

Name: aes_sbox_pipe

Overview:
- Multi-lane, pipelined AES byte-substitution unit, forward and inverse, with valid/ready flow control.
- Each lane is one GF(2^8) S-box.
- LANES=4 serves key-expansion SubWord; LANES=16 serves the round datapath (SubBytes / InvSubBytes).
- Sits between the AddRoundKey and ShiftRows stages.
- Mode and a sideband tag travel with each beat, so forward and inverse beats can be interleaved back to back.

Parameters:
- LANES, 16, number of byte lanes processed per beat (1..16).
- STAGES, 2, pipeline register stages and latency in cycles (1..3).
- TAG_W, 4, width of the sideband tag carried alongside each beat (>=1).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid_i  input  1  input beat valid.
- in_ready_o  output  1  block accepts a beat this cycle.
- inv_i  input  1  0 = forward S-box, 1 = inverse S-box; sampled with the beat.
- tag_i  input  TAG_W  sideband tag, returned unchanged with the result.
- data_i  input  8*LANES  input bytes; lane k = data_i[8k+7:8k].
- out_valid_o  output  1  output beat valid.
- out_ready_i  input  1  downstream accepts the output beat.
- inv_o  output  1  mode of the output beat.
- tag_o  output  TAG_W  tag of the output beat.
- data_o  output  8*LANES  substituted bytes, same lane order as the input.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset:
  - All stage valid bits are cleared.
  - out_valid_o=0, inv_o=0, tag_o=0, data_o=0 (all stage data registers cleared).
  - in_ready_o=1 in the first cycle after rst deasserts.
- Reset mid-operation: every in-flight beat is dropped. No partial output may appear after reset.
- Per-lane function:
  - Forward mode (inv=0): data_o lane = AES S(x).
  - Inverse mode (inv=1): data_o lane = AES InvS(x).
  - Structure: input linear map (affine-inverse for inv=1), then shared GF(2^8) inversion, then output linear map (forward affine for inv=0).
  - Forward output must be bit-identical to the existing combinational aes_sbox.
- Pipeline:
  - STAGES register banks, each holding {valid, inv, tag, data}.
  - STAGES=1: register at the output only.
  - STAGES=2: registers after the GF inversion and at the output.
  - STAGES=3: additionally a register after the input linear map.
  - The mode bit is pipelined alongside so the output map uses the beat's own mode.
- Flow control:
  - Global stall. en = ~out_valid_o | out_ready_i.
  - When en=1, every stage loads from its predecessor, and stage 0 loads {in_valid_i & in_ready_o, inv_i, tag_i, f(data_i)}.
  - in_ready_o = en, combinational from out_ready_i and out_valid_o. No combinational path from in_valid_i to any output.
  - Latency is exactly STAGES cycles from acceptance to out_valid_o when out_ready_i is held high.
  - Throughput is 1 beat per cycle.
- Hold: while out_valid_o=1 and out_ready_i=0:
  - out_valid_o, inv_o, tag_o and data_o hold stable.
  - in_ready_o=0, and in_valid_i is ignored.
- Bubbles: internal bubbles are not compressed. Out_valid_o=0 beats emerge in the same positions as input gaps.
- Simultaneous events:
  - Input accept and output pop in the same cycle are legal and are the steady-state case.
  - rst has priority over every handshake.
- Data registers may load garbage when their valid bit is 0. data_o is only meaningful when out_valid_o=1, except after reset.

Decomposition:
- Shared package aes_pkg:
  - Byte-lane width constant (8).
  - Forward and inverse affine constants (0x63, 0x05).
  - STAGES range checks as elaboration-time asserts.
- One natural sub-module: aes_sbox_core.
  - Combinational, single lane.
  - Ports: inv, byte in, byte out, plus a split point after the GF inversion so that aes_sbox_pipe can insert the mid-pipeline register.
  - aes_sbox_pipe instantiates LANES copies of it and owns all registers and handshake logic.

Test Plan:
- LANES=4, STAGES=2, out_ready_i=1: beat data_i=0x00_01_53_FF, inv=0, tag=5 -> 2 cycles later out_valid_o=1, data_o=0x63_7C_ED_16, tag_o=5, inv_o=0.
- Inverse: data_i=0x63_7C_ED_16, inv=1, tag=9 -> data_o=0x00_01_53_FF, inv_o=1, tag_o=9.
- Exhaustive sweep: all 256 bytes in both modes, back to back with alternating inv:
  - one result per cycle, no gaps;
  - InvS(S(x))=x;
  - forward output matches the existing aes_sbox for every x.
- Backpressure: stream 8 beats with tags 0..7, drop out_ready_i for 3 cycles mid-stream:
  - data_o/tag_o are held during the stall;
  - in_ready_o=0 during the stall;
  - all 8 beats emerge in order, none lost or duplicated.
- Reset mid-flight: assert rst for 1 cycle with 2 beats in flight:
  - the next cycle shows out_valid_o=0, data_o=0, tag_o=0;
  - no stale beat ever appears afterwards.
- Parameter corners: run the first two scenarios for each of the following, checking that latency equals STAGES exactly:
  - LANES=1/STAGES=1;
  - LANES=16/STAGES=3.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants and GF(2^8) helpers for the AES byte-substitution datapath.
package aes_pkg;

  localparam int         BYTE_W     = 8;
  localparam logic [7:0] AFF_FWD_C  = 8'h63;
  localparam logic [7:0] AFF_INV_C  = 8'h05;
  localparam int         STAGES_MIN = 1;
  localparam int         STAGES_MAX = 3;
  localparam int         LANES_MAX  = 16;

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] aff_fwd(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
           ^ AFF_FWD_C;
  endfunction

  function automatic logic [7:0] aff_inv(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ AFF_INV_C;
  endfunction

endpackage

// File: rtl/aes_sbox_core.sv
// One combinational S-box lane, split into input map / inversion / output map
// so the parent can place pipeline registers between the segments.
module aes_sbox_core
  import aes_pkg::*;
(
  input  logic       map_inv,
  input  logic [7:0] raw,
  output logic [7:0] lin,
  input  logic [7:0] lin_q,
  output logic [7:0] gf,
  input  logic       out_inv,
  input  logic [7:0] gf_q,
  output logic [7:0] sub
);

  assign lin = map_inv ? aff_inv(raw) : raw;
  assign gf  = gf_inv(lin_q);
  assign sub = out_inv ? gf_q : aff_fwd(gf_q);

endmodule

// File: rtl/aes_sbox_pipe.sv
// Multi-lane pipelined AES S-box / inverse S-box with valid/ready and a global stall.
module aes_sbox_pipe
  import aes_pkg::*;
#(
  parameter int LANES  = 16,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic                      inv_i,
  input  logic [TAG_W-1:0]          tag_i,
  input  logic [BYTE_W*LANES-1:0]   data_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic                      inv_o,
  output logic [TAG_W-1:0]          tag_o,
  output logic [BYTE_W*LANES-1:0]   data_o
);

  localparam int DW = BYTE_W * LANES;

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("aes_sbox_pipe: STAGES must be in 1..3");
  end
  if (LANES < 1 || LANES > LANES_MAX) begin : g_bad_lanes
    $error("aes_sbox_pipe: LANES must be in 1..16");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("aes_sbox_pipe: TAG_W must be at least 1");
  end

  logic              en;
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] inv_q;
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic [DW-1:0]     dat_q [STAGES];
  logic [DW-1:0]     dat_d [STAGES];
  logic [DW-1:0]     lin;
  logic [DW-1:0]     lin_q;
  logic [DW-1:0]     gf;
  logic [DW-1:0]     gf_q;
  logic [DW-1:0]     sub;
  logic              out_inv;

  // Cut points: output only; +after inversion; +after input map.
  if (STAGES == 1) begin : g_s1
    assign lin_q    = lin;
    assign gf_q     = gf;
    assign out_inv  = inv_i;
    assign dat_d[0] = sub;
  end else if (STAGES == 2) begin : g_s2
    assign lin_q    = lin;
    assign gf_q     = dat_q[0];
    assign out_inv  = inv_q[0];
    assign dat_d[0] = gf;
    assign dat_d[1] = sub;
  end else begin : g_s3
    assign lin_q    = dat_q[0];
    assign gf_q     = dat_q[1];
    assign out_inv  = inv_q[1];
    assign dat_d[0] = lin;
    assign dat_d[1] = gf;
    assign dat_d[2] = sub;
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    aes_sbox_core u_core (
      .map_inv (inv_i),
      .raw     (data_i[BYTE_W*k +: BYTE_W]),
      .lin     (lin[BYTE_W*k +: BYTE_W]),
      .lin_q   (lin_q[BYTE_W*k +: BYTE_W]),
      .gf      (gf[BYTE_W*k +: BYTE_W]),
      .out_inv (out_inv),
      .gf_q    (gf_q[BYTE_W*k +: BYTE_W]),
      .sub     (sub[BYTE_W*k +: BYTE_W])
    );
  end

  assign en         = ~out_valid_o | out_ready_i;
  assign in_ready_o = en;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      inv_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        tag_q[s] <= '0;
        dat_q[s] <= '0;
      end
    end else if (en) begin
      vld_q[0] <= in_valid_i & en;
      inv_q[0] <= inv_i;
      tag_q[0] <= tag_i;
      dat_q[0] <= dat_d[0];
      for (int s = 1; s < STAGES; s++) begin
        vld_q[s] <= vld_q[s-1];
        inv_q[s] <= inv_q[s-1];
        tag_q[s] <= tag_q[s-1];
        dat_q[s] <= dat_d[s];
      end
    end
  end

  assign out_valid_o = vld_q[STAGES-1];
  assign inv_o       = inv_q[STAGES-1];
  assign tag_o       = tag_q[STAGES-1];
  assign data_o      = dat_q[STAGES-1];

endmodule

// File: tb/tb_aes_sbox_pipe.sv
// Directed bench for aes_sbox_pipe: main 4-lane/2-stage instance plus 1/1 and 16/3 corners.
module tb_aes_sbox_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid;
  logic         inv_in;
  logic         out_ready;
  logic [3:0]   tag_in;
  logic [31:0]  data_a;
  logic [7:0]   data_b;
  logic [127:0] data_c;

  logic         rdy_a, vld_a, invo_a;
  logic [3:0]   tag_a;
  logic [31:0]  dout_a;
  logic         rdy_b, vld_b, invo_b;
  logic [3:0]   tag_b;
  logic [7:0]   dout_b;
  logic         rdy_c, vld_c, invo_c;
  logic [3:0]   tag_c;
  logic [127:0] dout_c;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]    sbox [256];
  logic [2047:0] sb_flat;
  logic [36:0]   sb_q [$];

  aes_sbox_pipe #(.LANES(4), .STAGES(2), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy_a), .inv_i(inv_in),
    .tag_i(tag_in), .data_i(data_a), .out_valid_o(vld_a), .out_ready_i(out_ready),
    .inv_o(invo_a), .tag_o(tag_a), .data_o(dout_a));

  aes_sbox_pipe #(.LANES(1), .STAGES(1), .TAG_W(4)) dut_s1 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy_b), .inv_i(inv_in),
    .tag_i(tag_in), .data_i(data_b), .out_valid_o(vld_b), .out_ready_i(out_ready),
    .inv_o(invo_b), .tag_o(tag_b), .data_o(dout_b));

  aes_sbox_pipe #(.LANES(16), .STAGES(3), .TAG_W(4)) dut_s3 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy_c), .inv_i(inv_in),
    .tag_i(tag_in), .data_i(data_c), .out_valid_o(vld_c), .out_ready_i(out_ready),
    .inv_o(invo_c), .tag_o(tag_c), .data_o(dout_c));

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // One beat into all three instances at once; measures each latency and result.
  task automatic beat_all(input logic inv, input logic [3:0] tag,
                          input logic [31:0] da, input logic [7:0] db, input logic [127:0] dc,
                          input logic [31:0] ea, input logic [7:0] eb, input logic [127:0] ec);
    int lat_a, lat_b, lat_c, cnt_a, cnt_b, cnt_c;
    logic [36:0]  got_a;
    logic [12:0]  got_b;
    logic [132:0] got_c;
    lat_a = 0; lat_b = 0; lat_c = 0;
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    got_a = '0; got_b = '0; got_c = '0;
    in_valid = 1'b1; inv_in = inv; tag_in = tag;
    data_a = da; data_b = db; data_c = dc;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) in_valid = 1'b0;
      if (vld_a) begin cnt_a++; if (lat_a == 0) begin lat_a = i; got_a = {invo_a, tag_a, dout_a}; end end
      if (vld_b) begin cnt_b++; if (lat_b == 0) begin lat_b = i; got_b = {invo_b, tag_b, dout_b}; end end
      if (vld_c) begin cnt_c++; if (lat_c == 0) begin lat_c = i; got_c = {invo_c, tag_c, dout_c}; end end
    end
    chk("lat_l4s2",   128'(lat_a), 128'(2));
    chk("cnt_l4s2",   128'(cnt_a), 128'(1));
    chk("beat_l4s2",  128'(got_a), 128'({inv, tag, ea}));
    chk("lat_l1s1",   128'(lat_b), 128'(1));
    chk("cnt_l1s1",   128'(cnt_b), 128'(1));
    chk("beat_l1s1",  128'(got_b), 128'({inv, tag, eb}));
    chk("lat_l16s3",  128'(lat_c), 128'(3));
    chk("cnt_l16s3",  128'(cnt_c), 128'(1));
    chk("data_l16s3", got_c[127:0], ec);
    chk("side_l16s3", 128'(got_c[132:128]), 128'({inv, tag}));
  endtask

  initial begin
    int sent, got, gaps, stale;
    logic seen, stall;
    logic [7:0] x;
    logic [31:0] exp_d;

    rst = 1'b1; in_valid = 1'b0; inv_in = 1'b0; tag_in = '0; out_ready = 1'b1;
    data_a = '0; data_b = '0; data_c = '0;

    sb_flat = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    for (int i = 0; i < 256; i++) sbox[i] = sb_flat[2047-8*i -: 8];

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", 128'(vld_a), 128'(0));
    chk("rst_data",  128'(dout_a), 128'(0));
    chk("rst_tag",   128'(tag_a), 128'(0));
    chk("rst_inv",   128'(invo_a), 128'(0));
    chk("rst_ready", 128'(rdy_a), 128'(1));
    chk("rst_s3",    128'({vld_c, invo_c, tag_c}) | 128'(dout_c), 128'(0));

    // Known-answer beats, forward then inverse, on all three configurations.
    beat_all(1'b0, 4'd5, 32'h0001_53ff, 8'h53, {4{32'h0001_53ff}},
             32'h637c_ed16, 8'hed, {4{32'h637c_ed16}});
    beat_all(1'b1, 4'd9, 32'h637c_ed16, 8'hed, {4{32'h637c_ed16}},
             32'h0001_53ff, 8'h53, {4{32'h0001_53ff}});

    // All 256 bytes, forward and inverse beats interleaved back to back.
    sent = 0; got = 0; gaps = 0; seen = 1'b0;
    sb_q.delete();
    for (int cyc = 0; cyc < 200 && got < 128; cyc++) begin
      if (sent < 128) begin
        for (int k = 0; k < 4; k++) begin
          x = 8'(4 * (sent / 2) + k);
          data_a[8*k +: 8] = sent[0] ? sbox[x] : x;
          exp_d[8*k +: 8]  = sent[0] ? x : sbox[x];
        end
        inv_in = sent[0]; tag_in = 4'(sent); in_valid = 1'b1;
        sb_q.push_back({sent[0], 4'(sent), exp_d});
        sent++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (vld_a) begin
        seen = 1'b1;
        if (sb_q.size() == 0) chk("sweep_extra", 128'(1), 128'(0));
        else chk("sweep_beat", 128'({invo_a, tag_a, dout_a}), 128'(sb_q.pop_front()));
        got++;
      end else if (seen) begin
        gaps++;
      end
    end
    in_valid = 1'b0;
    chk("sweep_count", 128'(got), 128'(128));
    chk("sweep_gaps",  128'(gaps), 128'(0));
    repeat (4) @(negedge clk);

    // Eight tagged beats with a three-cycle downstream stall in the middle.
    sent = 0; got = 0;
    sb_q.delete();
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      stall = (cyc >= 5 && cyc < 8);
      out_ready = ~stall;
      #1;
      if (vld_a) begin
        if (sb_q.size() == 0) chk("bp_extra", 128'(1), 128'(0));
        else begin
          chk("bp_beat", 128'({invo_a, tag_a, dout_a}), 128'(sb_q[0]));
          if (out_ready) begin
            void'(sb_q.pop_front());
            got++;
          end
        end
      end
      if (stall) begin
        chk("bp_stall_valid", 128'(vld_a), 128'(1));
        chk("bp_stall_ready", 128'(rdy_a), 128'(0));
      end
      if (sent < 8) begin
        for (int k = 0; k < 4; k++) begin
          x = 8'(8'h40 + 4 * sent + k);
          data_a[8*k +: 8] = x;
          exp_d[8*k +: 8]  = sbox[x];
        end
        inv_in = 1'b0; tag_in = 4'(sent); in_valid = 1'b1;
        if (rdy_a) begin
          sb_q.push_back({1'b0, 4'(sent), exp_d});
          sent++;
        end
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_sent",  128'(sent), 128'(8));
    chk("bp_count", 128'(got), 128'(8));
    stale = 0;
    repeat (4) begin
      @(negedge clk);
      if (vld_a) stale++;
    end
    chk("bp_no_dup", 128'(stale), 128'(0));

    // Reset with two beats in flight, held by a stalled output.
    out_ready = 1'b0;
    in_valid = 1'b1; inv_in = 1'b0; tag_in = 4'ha; data_a = 32'h1122_3344;
    @(negedge clk);
    tag_in = 4'hb; data_a = 32'h5566_7788;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_loaded", 128'(vld_a), 128'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_valid", 128'(vld_a), 128'(0));
    chk("mid_data",  128'(dout_a), 128'(0));
    chk("mid_tag",   128'(tag_a), 128'(0));
    chk("mid_inv",   128'(invo_a), 128'(0));
    chk("mid_ready", 128'(rdy_a), 128'(1));
    chk("mid_corners", 128'({vld_b, vld_c, dout_b}) | 128'(dout_c), 128'(0));
    out_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (vld_a || vld_b || vld_c) stale++;
    end
    chk("mid_no_stale", 128'(stale), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
